// File: rtl/store_narrow_rmw_if.sv
// Store request / data memory port bundle for store_narrow_rmw.
// The slave view is the narrowing block; the master view is the pipeline plus memory.
interface store_narrow_rmw_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic              done;
  logic              misaligned_err;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rd_data,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, done, misaligned_err
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rd_data,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, done, misaligned_err
  );
endinterface

// File: rtl/store_narrow_rmw.sv
// Narrows a register value to byte/half/word and stores it into a word-wide memory
// without byte enables, using read-modify-write for sub-word stores.
module store_narrow_rmw #(
  parameter int ADDR_W = 10
) (
  input logic               clk,
  input logic               reset,
  store_narrow_rmw_if.slave bus
);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic [15:0]       data_q;
  logic [31:0]       wr_data_q;
  logic [31:0]       merged;
  logic              err_q;
  logic              accept;
  logic              aligned;
  logic              unused_addr_bits;

  // Upper address bits fall outside the memory; stores wrap modulo its size.
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    aligned = 1'b0;
    case (bus.req_size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~bus.req_addr[0];
      SZ_WORD: aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && aligned) state_d = (bus.req_size == SZ_WORD) ? WRITE : READ;
      READ:    state_d = MERGE;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the selected lane(s) are replaced; the rest of the word is preserved.
  always_comb begin
    merged = bus.mem_rd_data;
    if (size_q == SZ_BYTE) merged[{lane_q, 3'b000} +: 8]   = data_q[7:0];
    else                   merged[{lane_q[1], 4'b0000} +: 16] = data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr_q   <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      data_q    <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && !aligned;
      if (accept && aligned) begin
        waddr_q <= bus.req_addr[ADDR_W+1:2];
        lane_q  <= bus.req_addr[1:0];
        size_q  <= bus.req_size;
        data_q  <= bus.req_data[15:0];
        if (bus.req_size == SZ_WORD) wr_data_q <= bus.req_data;
      end
      if (state_q == MERGE) wr_data_q <= merged;
    end
  end

  assign bus.req_ready      = (state_q == IDLE) && !reset;
  assign bus.mem_addr       = waddr_q;
  assign bus.mem_rd_en      = (state_q == READ);
  assign bus.mem_wr_en      = (state_q == WRITE);
  assign bus.mem_wr_data    = wr_data_q;
  assign bus.done           = (state_q == WRITE);
  assign bus.misaligned_err = err_q;
endmodule
